// File: rtl/instr_encoder_loader_if.sv
// Field-form instruction stream into the loader and the imem write port out of it.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_kind, rs, rt, rd, funct, imm, target,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_kind, rs, rt, rd, funct, imm, target,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes the control-unit MIPS subset into machine words and streams them
// sequentially into imem, one word per cycle, one cycle of write latency.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_loader_if.slave bus,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              err_reg, err_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              ready;
  logic              legal;
  logic [31:0]       enc_word;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (bus.in_kind)
      3'd0:    enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, bus.funct};
      3'd1:    enc_word = {6'b001000, bus.rs, bus.rt, bus.imm};
      3'd2:    enc_word = {6'b100011, bus.rs, bus.rt, bus.imm};
      3'd3:    enc_word = {6'b101011, bus.rs, bus.rt, bus.imm};
      3'd4:    enc_word = {6'b000100, bus.rs, bus.rt, bus.imm};
      3'd5:    enc_word = {6'b000010, bus.target};
      default: legal    = 1'b0;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    err_next       = err_reg;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    ready          = 1'b0;
    if (state_reg == LOAD) begin
      ready = !start && (count_reg != DEPTH_C);
    end
    if (start) begin
      // start wins over any offered instruction in the same cycle
      state_next = LOAD;
      count_next = '0;
      err_next   = 1'b0;
    end else if (ready && bus.in_valid) begin
      if (legal) begin
        mem_we_next    = 1'b1;
        mem_addr_next  = count_reg[ADDR_W-1:0];
        mem_wdata_next = enc_word;
        count_next     = count_reg + 1'b1;
        if (count_next == DEPTH_C) begin
          state_next = FULL;
        end
      end else begin
        err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      err_reg       <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      err_reg       <= err_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign count         = count_reg;
  assign full          = (count_reg == DEPTH_C);
  assign err           = err_reg;
endmodule
